// File: rtl/jt51_wrq_if.sv
// jt51_wrq CPU-side bus: data, strobe, a0, busy and overflow flags.
// The CPU drives the master side, the write queue is the slave.
interface jt51_wrq_if;
  logic [7:0] din;
  logic       write;
  logic       a0;
  logic       busy;
  logic       ovf;
  logic       ovf_clr;

  modport master (
    output din, write, a0, ovf_clr,
    input  busy, ovf
  );

  modport slave (
    input  din, write, a0, ovf_clr,
    output busy, ovf
  );
endinterface

// File: rtl/jt51_wrq.sv
// jt51_wrq: buffered JT51 register write port with paced issue.
// CPU writes are queued and replayed BUSY_CYC cen ticks apart.
module jt51_wrq #(
  parameter int DEPTH     = 4,
  parameter int BUSY_CYC  = 32,
  parameter int BUSY_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  jt51_wrq_if.slave              cpu,
  output logic [$clog2(DEPTH):0] level,
  output logic                   wr_stb,
  output logic [7:0]             wr_addr,
  output logic [7:0]             wr_data,
  input  logic [7:0]             rd_addr,
  output logic [7:0]             rd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(BUSY_CYC);

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  entry_t        mem [DEPTH];
  logic [7:0]    shadow [256];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    sel;
  logic          old_write;
  logic          ovf_q;
  state_t        state;
  logic [CW-1:0] hold_cnt;

  logic   access;
  logic   full;
  logic   pop;
  logic   push;
  logic   drop;
  entry_t head;

  assign access = cpu.write & ~old_write;
  assign full   = (level == LW'(DEPTH));
  assign pop    = (state == IDLE) & cen & (level != '0);
  assign push   = access & cpu.a0 & (~full | pop);
  assign drop   = access & cpu.a0 & full & ~pop;
  assign head   = mem[rd_ptr];

  assign cpu.ovf  = ovf_q;
  assign cpu.busy = (BUSY_MODE == 1) ? full
                  : ((level != '0) | (state == HOLD));
  assign rd_data  = shadow[rd_addr];

  // CPU side: edge detect, address latch and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      old_write <= 1'b0;
      sel       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      old_write <= cpu.write;
      if (access & ~cpu.a0)
        sel <= cpu.din;
      if (drop)
        ovf_q <= 1'b1;
      else if (cpu.ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  // FIFO pointers and true occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        push & ~pop: level <= level + LW'(1);
        pop & ~push: level <= level - LW'(1);
        default:     level <= level;
      endcase
    end
  end

  // FIFO storage; at full with a pop the slot is read before reuse
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{addr: sel, data: cpu.din};
  end

  // Shadow copy updated on the same edge that raises wr_stb
  always_ff @(posedge clk) begin
    if (pop)
      shadow[head.addr] <= head.data;
  end

  // Issue FSM: pop on cen, then hold for BUSY_CYC-1 more cen ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      wr_stb   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_stb <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            wr_addr  <= head.addr;
            wr_data  <= head.data;
            wr_stb   <= 1'b1;
            hold_cnt <= CW'(1);
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (cen) begin
            if (hold_cnt == CW'(BUSY_CYC - 1))
              state <= IDLE;
            else
              hold_cnt <= hold_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt51_wrq.sv
// Bench for jt51_wrq: directed scenarios plus random traffic,
// compared every clk against a queue-based reference model.
module tb_jt51_wrq;
  localparam int DEPTH = 4;
  localparam int BC    = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cen = 1'b0;
  logic [7:0] rd_addr = 8'h00;

  logic [2:0] level0, level1;
  logic       stb0, stb1;
  logic [7:0] addr0, addr1, data0, data1, rdd0, rdd1;

  jt51_wrq_if i0 ();
  jt51_wrq_if i1 ();

  assign i1.din     = i0.din;
  assign i1.write   = i0.write;
  assign i1.a0      = i0.a0;
  assign i1.ovf_clr = i0.ovf_clr;

  jt51_wrq #(.DEPTH(DEPTH), .BUSY_CYC(BC), .BUSY_MODE(0)) u0 (
    .clk(clk), .rst(rst), .cen(cen), .cpu(i0.slave),
    .level(level0), .wr_stb(stb0), .wr_addr(addr0),
    .wr_data(data0), .rd_addr(rd_addr), .rd_data(rdd0)
  );

  jt51_wrq #(.DEPTH(DEPTH), .BUSY_CYC(BC), .BUSY_MODE(1)) u1 (
    .clk(clk), .rst(rst), .cen(cen), .cpu(i1.slave),
    .level(level1), .wr_stb(stb1), .wr_addr(addr1),
    .wr_data(data1), .rd_addr(rd_addr), .rd_data(rdd1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // reference model: entries in a queue, hold as a countdown of cen ticks
  logic [15:0] q[$];
  logic [7:0]  m_sel;
  bit          m_oldw;
  int          m_hold;
  bit          m_stb;
  logic [7:0]  m_addr, m_data;
  bit          m_ovf;
  logic [7:0]  m_shadow [256];
  bit          known [256];

  function automatic void m_reset();
    q.delete();
    m_sel  = 8'h00;
    m_oldw = 1'b0;
    m_hold = 0;
    m_stb  = 1'b0;
    m_addr = 8'h00;
    m_data = 8'h00;
    m_ovf  = 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    int          n;
    bit          acc, popm, pushok, drop;
    logic [15:0] e;
    if (rst) begin
      m_reset();
    end else begin
      n      = q.size();
      acc    = i0.write && !m_oldw;
      m_oldw = i0.write;
      popm   = (m_hold == 0) && cen && (n > 0);
      pushok = acc && i0.a0 && ((n < DEPTH) || popm);
      drop   = acc && i0.a0 && !pushok;
      m_stb  = 1'b0;
      if (popm) begin
        e = q.pop_front();
        m_addr = e[15:8];
        m_data = e[7:0];
        m_stb  = 1'b1;
        m_shadow[m_addr] = m_data;
        known[m_addr]    = 1'b1;
        m_hold = BC - 1;
      end else if (m_hold > 0 && cen) begin
        m_hold--;
      end
      if (pushok)
        q.push_back({m_sel, i0.din});
      if (acc && !i0.a0)
        m_sel = i0.din;
      if (drop)
        m_ovf = 1'b1;
      else if (i0.ovf_clr)
        m_ovf = 1'b0;
    end
  end

  int cyc     = 0;
  bit gap_en  = 1'b0;
  int last    = -1;
  int npulse  = 0;

  always @(negedge clk) begin
    cyc++;
    check("wr_stb",  stb0,  m_stb);
    check("wr_addr", addr0, m_addr);
    check("wr_data", data0, m_data);
    check("level",   level0, q.size());
    check("busy0",   i0.busy, (q.size() != 0) || (m_hold > 0));
    check("ovf",     i0.ovf, m_ovf);
    check("level1",  level1, q.size());
    check("busy1",   i1.busy, q.size() == DEPTH);
    check("stb1",    stb1, m_stb);
    if (known[rd_addr]) begin
      check("rd_data",  rdd0, m_shadow[rd_addr]);
      check("rd_data1", rdd1, m_shadow[rd_addr]);
    end
    if (stb0)
      npulse++;
    if (gap_en && stb0) begin
      if (last >= 0)
        check("gap", cyc - last, 2 * BC);
      last = cyc;
    end
  end

  int cen_mode = 1;
  bit ph       = 1'b0;
  bit rnd_rd   = 1'b0;

  task automatic step(input bit w, input bit a, input logic [7:0] d,
                      input bit clr = 1'b0);
    i0.write   = w;
    i0.a0      = a;
    i0.din     = d;
    i0.ovf_clr = clr;
    case (cen_mode)
      0: cen = 1'b0;
      1: cen = 1'b1;
      2: begin ph = ~ph; cen = ph; end
      default: cen = ($urandom_range(0, 3) == 0);
    endcase
    if (rnd_rd)
      rd_addr = 8'($urandom_range(0, 7));
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    step(1'b1, 1'b0, a);
    step(1'b0, 1'b0, a);
    step(1'b1, 1'b1, d);
    step(1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    int p0;
    m_reset();
    i0.write   = 1'b0;
    i0.a0      = 1'b0;
    i0.din     = 8'h00;
    i0.ovf_clr = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    // single write at reset defaults, cen every clk
    cen_mode = 1;
    rd_addr  = 8'h14;
    p0 = npulse;
    wr(8'h14, 8'h3A);
    idle(45);
    check("single_pulses", npulse - p0, 1);

    // burst paced by cen every second clk
    cen_mode = 2;
    rd_addr  = 8'h22;
    gap_en   = 1'b1;
    last     = -1;
    p0 = npulse;
    for (int i = 0; i < 4; i++)
      wr(8'(8'h20 + i), 8'(8'h11 * (i + 1)));
    idle(300);
    gap_en = 1'b0;
    check("burst_pulses", npulse - p0, 4);

    // overflow with cen held low
    cen_mode = 0;
    p0 = npulse;
    for (int i = 0; i < 5; i++)
      wr(8'(8'h30 + i), 8'(8'hA0 + i));
    check("ovf_level", level0, DEPTH);
    check("ovf_set", i0.ovf, 1);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    check("ovf_clr", i0.ovf, 0);
    cen_mode = 1;
    idle(150);
    check("ovf_pulses", npulse - p0, 4);

    // full FIFO with a push landing on the issue clk
    cen_mode = 0;
    p0 = npulse;
    for (int i = 0; i < 4; i++)
      wr(8'(8'h40 + i), 8'(8'hB0 + i));
    cen_mode = 1;
    step(1'b1, 1'b1, 8'h99);
    check("pp_level", level0, DEPTH);
    check("pp_ovf", i0.ovf, 0);
    step(1'b0, 1'b1, 8'h99);
    idle(180);
    check("pp_pulses", npulse - p0, 5);

    // write held high for ten clks gives one push
    cen_mode = 0;
    step(1'b1, 1'b0, 8'h50);
    step(1'b0, 1'b0, 8'h50);
    repeat (10) step(1'b1, 1'b1, 8'h77);
    step(1'b0, 1'b1, 8'h77);
    check("held_level", level0, 1);

    // reset in the middle of a hold
    wr(8'h51, 8'h01);
    wr(8'h52, 8'h02);
    cen_mode = 1;
    step(1'b0, 1'b1, 8'h00);
    cen_mode = 0;
    idle(2);
    check("pre_rst_level", level0, 2);
    rst = 1'b1;
    #1;
    check("rst_level", level0, 0);
    check("rst_busy", i0.busy, 0);
    check("rst_addr", addr0, 0);
    step(1'b0, 1'b1, 8'h00);
    rst = 1'b0;
    cen_mode = 1;
    p0 = npulse;
    rd_addr = 8'h55;
    wr(8'h55, 8'h66);
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_pulse", npulse - p0, 1);
    idle(40);

    // random traffic with sparse cen
    cen_mode = 3;
    rnd_rd   = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      bit a;
      a = ($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 1)), a,
           a ? 8'($urandom) : 8'($urandom_range(0, 7)),
           ($urandom_range(0, 31) == 0));
    end
    cen_mode = 1;
    idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
